rcnf_arbiter: RTL

RCNF_ARBITER -- requirements
Module: rcnf_arbiter

---
 rtl/rcnf_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rcnf_arbiter.sv
// ---------------------------------------------------------------------------
// rcnf_arbiter
//
// Two-requester arbiter in front of a single-port register RAM. At most one
// requester is granted per cycle; the grant is combinational from the current
// requests and the priority state. Read returns come back two cycles after
// the grant and are steered to the right requester by a two-stage
// {valid, owner} tag pipeline.
//
// Configuration macro:
//   RCNF_ARB_RR_EN  defined   : round-robin; after each grant the pointer
//                               favours the other requester.
//                   undefined : fixed priority, requester 0 wins contention,
//                               and no pointer register exists.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   mN_address/byteenable/
//   mN_read/mN_write/
//   mN_writedata               command from requester N (N = 0, 1)
//   mN_waitrequest             command stalled this cycle; hold it stable
//   mN_readdata                mirror of ram_readdata
//   mN_readdatavalid           one-cycle read-return strobe
//   ram_address/byteenable/
//   ram_writedata/ram_chipselect/
//   ram_write                  command to the register RAM
//   ram_clken                  constant 1
//   ram_reset_req              constant 0
//   ram_readdata               registered read data from the RAM
// ---------------------------------------------------------------------------
module rcnf_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic                  ram_clken,
    output logic                  ram_reset_req,
    input  logic [DATA_W-1:0]     ram_readdata
);

    logic req0;
    logic req1;
    logic prefer1;     // 1: requester 1 wins contention this cycle
    logic gnt0;
    logic gnt1;
    logic rd_accept;   // a pure read (no write) is granted this cycle

    // Tag pipeline: stage 1 = granted last cycle, stage 2 = data on RAM now.
    logic tag1_valid_q, tag1_valid_d;
    logic tag1_owner_q, tag1_owner_d;
    logic tag2_valid_q, tag2_valid_d;
    logic tag2_owner_q, tag2_owner_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef RCNF_ARB_RR_EN
    logic ptr_q, ptr_d;

    // Every grant (contended or not) hands preference to the other side.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign prefer1 = ptr_q;
`else
    assign prefer1 = 1'b0;
`endif

    // A lone requester always wins; priority only breaks ties. Reset holds
    // the grant off entirely.
    assign gnt0 = ~reset & req0 & (~req1 | ~prefer1);
    assign gnt1 = ~reset & req1 & (~req0 |  prefer1);

    assign m0_waitrequest = reset | (req0 & ~gnt0);
    assign m1_waitrequest = reset | (req1 & ~gnt1);

    // Command mux toward the RAM; fields are don't-care when not selected
    // but are kept at zero to make traces readable.
    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        if (gnt0) begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_writedata  = m0_writedata;
            ram_chipselect = 1'b1;
            ram_write      = m0_write;
        end else if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            ram_chipselect = 1'b1;
            ram_write      = m1_write;
        end
    end

    assign ram_clken     = 1'b1;
    assign ram_reset_req = 1'b0;

    // Read+write together performs the write only, so no return is tracked.
    assign rd_accept = (gnt0 & m0_read & ~m0_write) |
                       (gnt1 & m1_read & ~m1_write);

    always_comb begin
        tag1_valid_d = rd_accept;
        tag1_owner_d = gnt1;
        tag2_valid_d = tag1_valid_q;
        tag2_owner_d = tag1_owner_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag1_valid_q <= 1'b0;
            tag1_owner_q <= 1'b0;
            tag2_valid_q <= 1'b0;
            tag2_owner_q <= 1'b0;
        end else begin
            tag1_valid_q <= tag1_valid_d;
            tag1_owner_q <= tag1_owner_d;
            tag2_valid_q <= tag2_valid_d;
            tag2_owner_q <= tag2_owner_d;
        end
    end

    assign m0_readdatavalid = tag2_valid_q & ~tag2_owner_q;
    assign m1_readdatavalid = tag2_valid_q &  tag2_owner_q;

    assign m0_readdata = ram_readdata;
    assign m1_readdata = ram_readdata;

endmodule
